// File: rtl/io_pkg.sv
// Shared constants for the GPIO responder: IO window base and register offsets.
package io_pkg;
  localparam logic [31:0] IO_BASE = 32'h0002_0000;

  localparam logic [4:0] IO_SW_OFF    = 5'h04;
  localparam logic [4:0] IO_BTN_OFF   = 5'h08;
  localparam logic [4:0] IO_EDGE_OFF  = 5'h0C;
  localparam logic [4:0] IO_LED_OFF   = 5'h10;
  localparam logic [4:0] IO_TIMER_OFF = 5'h14;

  function automatic logic [4:0] io_word_off(input logic [31:0] a);
    return {a[4:2], 2'b00};
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, stability counter and accepted level.
// o_rise pulses in the cycle the accepted level goes 0->1.
module btn_debounce
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_stable,
  output logic o_rise
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_done;

  assign w_diff   = r_s2 ^ r_stable;
  assign w_done   = w_diff && (r_cnt == LAST);
  assign o_stable = r_stable;
  assign o_rise   = w_done & r_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      // any return to the accepted level restarts qualification
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt    <= '0;
        r_stable <= r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/io_responder.sv
// Memory-mapped GPIO responder: switches, debounced buttons, edge latch, LEDs.
// Define IO_TIMER_EN to add the free-running 32-bit timer at offset 0x14.
module io_responder
  import io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = IO_BASE,
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter int          NUM_BTN         = 5,
  parameter int          NUM_SW          = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        addr,
  input  logic [31:0]        wr_data,
  input  logic               write_en,
  input  logic               read_en,
  output logic [31:0]        rd_data,
  output logic               sel,
  input  logic [NUM_BTN-1:0] BTN,
  input  logic [NUM_SW-1:0]  SW,
  output logic [15:0]        LED
);
  logic [NUM_SW-1:0]  r_sw_s1;
  logic [NUM_SW-1:0]  r_sw_s2;
  logic [NUM_BTN-1:0] w_stable;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_clr;
  logic [NUM_BTN-1:0] r_edge;
  logic [15:0]        r_led;
  logic [31:0]        w_timer;
  logic [31:0]        w_rd;
  logic [4:0]         w_off;
  logic               w_wr;
  logic               w_unused;

  assign sel      = (addr[31:5] == BASE_ADDR[31:5]);
  assign w_off    = io_word_off(addr);
  assign w_wr     = write_en & sel;
  assign LED      = r_led;
  assign w_unused = ^{addr[1:0], wr_data};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset   (reset),
      .i_btn   (BTN[i]),
      .o_stable(w_stable[i]),
      .o_rise  (w_rise[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= SW;
      r_sw_s2 <= r_sw_s1;
    end
  end

  always_comb begin
    w_clr = '0;
    if (w_wr && (w_off == IO_EDGE_OFF)) begin
      w_clr = wr_data[NUM_BTN-1:0];
    end
  end

  // a new rising edge beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edge <= '0;
    end else begin
      r_edge <= (r_edge & ~w_clr) | w_rise;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led <= '0;
    end else if (w_wr && ((w_off == IO_LED_OFF) ||
                          (w_off == IO_BTN_OFF))) begin
      r_led <= wr_data[15:0];
    end
  end

`ifdef IO_TIMER_EN
  logic [31:0] r_timer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_wr && (w_off == IO_TIMER_OFF)) begin
      r_timer <= wr_data;
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end

  assign w_timer = r_timer;
`else
  assign w_timer = '0;
`endif

  always_comb begin
    w_rd = '0;
    if (read_en && sel) begin
      case (w_off)
        IO_SW_OFF:    w_rd = 32'(r_sw_s2);
        IO_BTN_OFF:   w_rd = 32'(w_stable);
        IO_EDGE_OFF:  w_rd = 32'(r_edge);
        IO_LED_OFF:   w_rd = {16'b0, r_led};
        IO_TIMER_OFF: w_rd = w_timer;
        default:      w_rd = '0;
      endcase
    end
  end

  assign rd_data = w_rd;
endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder with a short debounce window.
// Expectations are queued by the stimulus and checked at the falling edge.
module tb_io_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic        write_en = 1'b0;
  logic        read_en = 1'b0;
  logic [31:0] rd_data;
  logic        sel;
  logic [4:0]  BTN = '0;
  logic [15:0] SW = '0;
  logic [15:0] LED;

  localparam int K_RD  = 0;
  localparam int K_LED = 1;
  localparam int K_SEL = 2;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  io_responder #(
    .BASE_ADDR      (32'h0002_0000),
    .DEBOUNCE_CYCLES(4),
    .NUM_BTN        (5),
    .NUM_SW         (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wr_data (wr_data),
    .write_en(write_en),
    .read_en (read_en),
    .rd_data (rd_data),
    .sel     (sel),
    .BTN     (BTN),
    .SW      (SW),
    .LED     (LED)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : monitor
    chk_t        c;
    logic [31:0] got;
    while (q.size() > 0) begin
      c = q.pop_front();
      case (c.kind)
        K_LED:   got = {16'b0, LED};
        K_SEL:   got = {31'b0, sel};
        default: got = rd_data;
      endcase
      n_cmp++;
      if (got !== c.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", c.name, got, c.exp);
      end
    end
  end

  task automatic cyc(input logic [31:0] a, input logic [31:0] d,
                     input logic we, input logic re);
    @(posedge clk);
    #1;
    addr     = a;
    wr_data  = d;
    write_en = we;
    read_en  = re;
  endtask

  task automatic expect_v(input string n, input int k,
                          input logic [31:0] e);
    chk_t c;
    c.name = n;
    c.kind = k;
    c.exp  = e;
    q.push_back(c);
  endtask

  task automatic idle();
    cyc(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(a, d, 1'b1, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e,
                    input string n);
    cyc(a, 32'h0, 1'b0, 1'b1);
    expect_v(n, K_RD, e);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1: reset mid-run
    wr(32'h0002_0010, 32'h0000_0055);
    idle();
    expect_v("led_pre_rst", K_LED, 32'h55);
    idle();
    reset = 1'b1;
    expect_v("led_in_rst", K_LED, 32'h0);
    idle();
    reset = 1'b0;
    rd(32'h0002_0010, 32'h0, "rst_led_reg");
    rd(32'h0002_000C, 32'h0, "rst_edge");
    rd(32'h0002_0008, 32'h0, "rst_btn");
    cyc(32'h0001_FFFC, 32'h0, 1'b0, 1'b1);
    expect_v("sel_below", K_SEL, 32'h0);
    expect_v("rd_below", K_RD, 32'h0);
    cyc(32'h0002_001C, 32'h0, 1'b0, 1'b0);
    expect_v("sel_top", K_SEL, 32'h1);
    cyc(32'h0002_0020, 32'h0, 1'b0, 1'b0);
    expect_v("sel_above", K_SEL, 32'h0);

    // 2: switches through the synchroniser
    idle();
    SW = 16'hA5C3;
    idle();
    rd(32'h0002_0004, 32'h0000_A5C3, "sw_2clk");
    idle();
    SW = 16'h1234;
    rd(32'h0002_0007, 32'h0000_A5C3, "sw_old");
    rd(32'h0002_0004, 32'h0000_1234, "sw_new");

    // 3: LED via legacy port and LED register
    wr(32'h0002_0008, 32'hDEAD_BEEF);
    rd(32'h0002_0010, 32'h0000_BEEF, "led_rd");
    expect_v("led_pin", K_LED, 32'hBEEF);
    cyc(32'h0002_0010, 32'h0000_1234, 1'b1, 1'b1);
    expect_v("rd_prewrite", K_RD, 32'h0000_BEEF);
    rd(32'h0002_0010, 32'h0000_1234, "led_rw");
    cyc(32'h0002_0010, 32'h0, 1'b0, 1'b0);
    expect_v("rd_no_en", K_RD, 32'h0);
    wr(32'h0002_0030, 32'h0000_AAAA);
    wr(32'h0002_0000, 32'h0000_FFFF);
    rd(32'h0002_0000, 32'h0, "unmapped");
    expect_v("led_kept", K_LED, 32'h1234);

    // 4: glitch rejected, then a held press
    idle();
    BTN = 5'b00100;
    idle();
    idle();
    idle();
    BTN = 5'b00000;
    idle();
    idle();
    idle();
    rd(32'h0002_0008, 32'h0, "glitch_btn");
    rd(32'h0002_000C, 32'h0, "glitch_edge");
    idle();
    BTN = 5'b00100;
    repeat (4) idle();
    rd(32'h0002_0008, 32'h0, "btn_early");
    rd(32'h0002_0008, 32'h4, "btn_held");
    rd(32'h0002_000C, 32'h4, "edge_set");
    wr(32'h0002_000C, 32'h4);
    rd(32'h0002_000C, 32'h0, "edge_w1c");
    rd(32'h0002_0008, 32'h4, "btn_after_w1c");

    // 5: set beats simultaneous clear
    idle();
    BTN = 5'b00101;
    repeat (4) idle();
    wr(32'h0002_000C, 32'h1);
    rd(32'h0002_000C, 32'h1, "edge_set_wins");
    rd(32'h0002_0008, 32'h5, "btn_two");

    // 6: timer
    wr(32'h0002_0014, 32'hFFFF_FFFE);
    idle();
`ifdef IO_TIMER_EN
    rd(32'h0002_0014, 32'hFFFF_FFFF, "timer_pre_wrap");
    rd(32'h0002_0014, 32'h0000_0000, "timer_wrap");
`else
    rd(32'h0002_0014, 32'h0, "timer_absent");
    rd(32'h0002_0014, 32'h0, "timer_absent2");
`endif

    idle();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
